// File: rtl/imm_encoder_pkg.sv
// Shared stage-1 control constants: immediate-type codes used by the encoder
// and by anything that decodes its output.
package imm_encoder_pkg;

    localparam int IMM_TYPE_W = 3;

    // Code 3'd7 is deliberately left unassigned and reported as an error.
    typedef enum logic [IMM_TYPE_W-1:0] {
        R_TYPE     = 3'd0,
        I_TYPE     = 3'd1,
        ISTAR_TYPE = 3'd2,
        S_TYPE     = 3'd3,
        B_TYPE     = 3'd4,
        U_TYPE     = 3'd5,
        J_TYPE     = 3'd6
    } imm_type_e;

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate scatter: overlays imm onto base for the given type.
// Range checking is compiled in only with IMMENC_RANGE_CHECK_EN defined.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [IMM_TYPE_W-1:0] type_i,
    input  logic [31:0]           imm_i,
    input  logic [31:0]           base_i,
    output logic [31:0]           inst_o,
    output logic                  err_o
);

    logic badType;

    always_comb begin
        inst_o  = base_i;
        badType = 1'b0;
        case (type_i)
            R_TYPE: ;
            I_TYPE:     inst_o[31:20] = imm_i[11:0];
            ISTAR_TYPE: inst_o[24:20] = imm_i[4:0];
            S_TYPE: begin
                inst_o[31:25] = imm_i[11:5];
                inst_o[11:7]  = imm_i[4:0];
            end
            B_TYPE: begin
                inst_o[31]    = imm_i[12];
                inst_o[7]     = imm_i[11];
                inst_o[30:25] = imm_i[10:5];
                inst_o[11:8]  = imm_i[4:1];
            end
            U_TYPE:     inst_o[31:12] = imm_i[31:12];
            J_TYPE: begin
                inst_o[31]    = imm_i[20];
                inst_o[19:12] = imm_i[19:12];
                inst_o[20]    = imm_i[11];
                inst_o[30:21] = imm_i[10:1];
            end
            default:    badType = 1'b1;
        endcase
    end

`ifdef IMMENC_RANGE_CHECK_EN
    // A value is representable when every bit above the field's sign bit copies it.
    logic fits11, fits12, fits20, rangeErr;

    assign fits11 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fits12 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign fits20 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

    always_comb begin
        rangeErr = 1'b0;
        case (type_i)
            I_TYPE, S_TYPE: rangeErr = ~fits11;
            ISTAR_TYPE:     rangeErr = |imm_i[31:5];
            B_TYPE:         rangeErr = ~fits12 | imm_i[0];
            U_TYPE:         rangeErr = |imm_i[11:0];
            J_TYPE:         rangeErr = ~fits20 | imm_i[0];
            default:        rangeErr = 1'b0;
        endcase
    end

    assign err_o = badType | rangeErr;
`else
    assign err_o = badType;
`endif

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: S1 holds the raw beat, S2 the packed
// instruction. Optional range checking via IMMENC_RANGE_CHECK_EN.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IMM_TYPE_W-1:0] in_imm_type,
    input  logic [31:0]           in_imm,
    input  logic [31:0]           in_base,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic                  out_err,
    output logic [ERR_CNT_W-1:0]  err_count
);

    logic                  s1Valid_q;
    logic [IMM_TYPE_W-1:0] s1Type_q;
    logic [31:0]           s1Imm_q;
    logic [31:0]           s1Base_q;
    logic                  outValid_q;
    logic [31:0]           outInst_q;
    logic                  outErr_q;
    logic [ERR_CNT_W-1:0]  errCount_q;
    logic [ERR_CNT_W-1:0]  errCount_d;

    logic        s2Free, s1Adv, inFire, outFire;
    logic [31:0] packInst;
    logic        packErr;

    assign s2Free   = ~outValid_q | out_ready;
    assign s1Adv    = s1Valid_q & s2Free;
    assign in_ready = ~s1Valid_q | s2Free;
    assign inFire   = in_valid & in_ready;
    assign outFire  = outValid_q & out_ready;

    imm_pack u_pack (
        .type_i (s1Type_q),
        .imm_i  (s1Imm_q),
        .base_i (s1Base_q),
        .inst_o (packInst),
        .err_o  (packErr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1Valid_q <= 1'b0;
            s1Type_q  <= '0;
            s1Imm_q   <= '0;
            s1Base_q  <= '0;
        end else if (inFire) begin
            s1Valid_q <= 1'b1;
            s1Type_q  <= in_imm_type;
            s1Imm_q   <= in_imm;
            s1Base_q  <= in_base;
        end else if (s1Adv) begin
            s1Valid_q <= 1'b0;
        end
    end

    // S2 only moves when free, which keeps a stalled output beat stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValid_q <= 1'b0;
            outInst_q  <= '0;
            outErr_q   <= 1'b0;
        end else if (s2Free) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outInst_q <= packInst;
                outErr_q  <= packErr;
            end
        end
    end

    always_comb begin
        errCount_d = errCount_q;
        if (outFire && outErr_q && (errCount_q != {ERR_CNT_W{1'b1}})) begin
            errCount_d = errCount_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            errCount_q <= '0;
        end else begin
            errCount_q <= errCount_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_inst  = outInst_q;
    assign out_err   = outErr_q;
    assign err_count = errCount_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder; expectations follow IMMENC_RANGE_CHECK_EN.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_imm_type = '0;
    logic [31:0]   in_imm = '0;
    logic [31:0]   in_base = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_inst;
    logic          out_err;
    logic [CW-1:0] err_count;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] expQ[$];
    int          expErrCnt = 0;
    logic        randReady = 1'b0;

`ifdef IMMENC_RANGE_CHECK_EN
    localparam bit RANGE_ON = 1'b1;
`else
    localparam bit RANGE_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    imm_encoder #(.ERR_CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_imm_type (in_imm_type),
        .in_imm      (in_imm),
        .in_base     (in_base),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_err     (out_err),
        .err_count   (err_count)
    );

    // Reference encoder written from signed ranges and whole-word concatenation.
    function automatic logic [32:0] refEncode(input logic [2:0] t, input logic [31:0] imm,
                                              input logic [31:0] base);
        logic [31:0] r;
        logic        e;
        int          s;
        s = $signed(imm);
        r = base;
        e = 1'b0;
        case (t)
            3'd0: ;
            3'd1: begin r = {imm[11:0], base[19:0]}; e = (s < -2048) || (s > 2047); end
            3'd2: begin r = {base[31:25], imm[4:0], base[19:0]}; e = (imm > 32'd31); end
            3'd3: begin
                r = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
                e = (s < -2048) || (s > 2047);
            end
            3'd4: begin
                r = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
                e = (s < -4096) || (s > 4095) || imm[0];
            end
            3'd5: begin r = {imm[31:12], base[11:0]}; e = (imm[11:0] != 12'd0); end
            3'd6: begin
                r = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
                e = (s < -(1 << 20)) || (s > (1 << 20) - 1) || imm[0];
            end
            default: e = 1'b1;
        endcase
        if (!RANGE_ON && t <= 3'd6) e = 1'b0;
        return {e, r};
    endfunction

    // Output monitor: pops the scoreboard on each output transfer and checks stall stability.
    initial begin
        logic [32:0] e;
        logic [32:0] held;
        logic        holdPending;
        holdPending = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (holdPending && out_valid) begin
                    checks++;
                    if ({out_err, out_inst} !== held) begin
                        errors++;
                        $display("[TB] FAIL hold_stable got %h expected %h", {out_err, out_inst}, held);
                    end
                end
                holdPending = out_valid && !out_ready;
                held = {out_err, out_inst};
                if (out_valid && out_ready) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_beat got %h expected no beat", {out_err, out_inst});
                    end else begin
                        e = expQ.pop_front();
                        if ({out_err, out_inst} !== e) begin
                            errors++;
                            $display("[TB] FAIL beat got err=%b inst=%h expected err=%b inst=%h",
                                     out_err, out_inst, e[32], e[31:0]);
                        end
                        if (e[32] && expErrCnt < (1 << CW) - 1) expErrCnt++;
                    end
                end
            end else begin
                holdPending = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendBeat(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base,
                            input logic [32:0] exp);
        bit accepted;
        in_imm_type = t;
        in_imm      = imm;
        in_base     = base;
        in_valid    = 1'b1;
        expQ.push_back(exp);
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout got in_ready=0 expected 1");
        end
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending expected 0", expQ.size());
        end
        checks++;
        if (err_count !== CW'(expErrCnt)) begin
            errors++;
            $display("[TB] FAIL err_count got %0d expected %0d", err_count, expErrCnt);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        checks++;
        if ({out_valid, out_err, out_inst, err_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got v=%b e=%b i=%h c=%0d expected all zero",
                     out_valid, out_err, out_inst, err_count);
        end
        #11 reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        sendBeat(3'(I_TYPE), 32'hFFFFF800, 32'h00000013, {1'b0, 32'h80000013});
        sendBeat(3'(B_TYPE), 32'hFFFFFFFC, 32'h00000063, {1'b0, 32'hFE000EE3});
        sendBeat(3'(J_TYPE), 32'h00000800, 32'h0000006F, {1'b0, 32'h0010006F});
        sendBeat(3'(U_TYPE), 32'h12345001, 32'h00000037, {RANGE_ON, 32'h12345037});
        in_valid = 1'b0;
        drain();
        checks++;
        if (err_count !== (RANGE_ON ? CW'(1) : CW'(0))) begin
            errors++;
            $display("[TB] FAIL u_err_count got %0d expected %0d", err_count, RANGE_ON ? 1 : 0);
        end
        sendBeat(3'd7, 32'h00000000, 32'hDEADBEEF, {1'b1, 32'hDEADBEEF});
        sendBeat(3'(R_TYPE), 32'hFFFFFFFF, 32'h00C58533, {1'b0, 32'h00C58533});
        sendBeat(3'(ISTAR_TYPE), 32'h00000025, 32'h40001013, {RANGE_ON, 32'h40501013});
        drain();
    endtask

    task automatic test_latency();
        out_ready   = 1'b1;
        in_imm_type = 3'(S_TYPE);
        in_imm      = 32'hFFFFFFF0;
        in_base     = 32'h00002023;
        in_valid    = 1'b1;
        expQ.push_back({1'b0, 32'hFE002823});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency_n1 got out_valid=%b expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latency_n2 got out_valid=%b expected 1", out_valid);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [32:0] expA;
        expA = refEncode(3'(I_TYPE), 32'h00000005, 32'h00000093);
        out_ready   = 1'b0;
        in_imm_type = 3'(I_TYPE);
        in_imm      = 32'h00000005;
        in_base     = 32'h00000093;
        in_valid    = 1'b1;
        expQ.push_back(expA);
        @(posedge clk);
        #1;
        in_imm_type = 3'(U_TYPE);
        in_imm      = 32'hABCDE000;
        in_base     = 32'h000000B7;
        expQ.push_back(refEncode(3'(U_TYPE), 32'hABCDE000, 32'h000000B7));
        @(posedge clk);
        #1;
        in_imm_type = 3'(J_TYPE);
        in_imm      = 32'hFFF00000;
        in_base     = 32'h000000EF;
        expQ.push_back(refEncode(3'(J_TYPE), 32'hFFF00000, 32'h000000EF));
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_in_ready got %b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_err, out_inst} !== expA) begin
            errors++;
            $display("[TB] FAIL bp_hold got rdy=%b v=%b beat=%h expected rdy=0 v=1 beat=%h",
                     in_ready, out_valid, {out_err, out_inst}, expA);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release got in_ready=%b expected 1", in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_stream%0d got out_valid=%b expected 1", k, out_valid);
            end
            if (k == 0) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_done got out_valid=%b expected 0", out_valid);
        end
        drain();
    endtask

    task automatic test_random();
        logic [2:0]  t;
        logic [31:0] imm, base;
        int          v;
        randReady = 1'b1;
        for (int n = 0; n < 80; n++) begin
            t    = 3'($urandom_range(0, 7));
            base = $urandom;
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: begin v = int'($urandom_range(0, 8191)) - 4096; imm = v; end
                2: imm = $urandom_range(0, 63);
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            if ($urandom_range(0, 1) == 0) imm[0] = 1'b0;
            sendBeat(t, imm, base, refEncode(t, imm, base));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid  = 1'b0;
        randReady = 1'b0;
        #1;
        drain();
    endtask

    task automatic test_midreset();
        out_ready = 1'b0;
        sendBeat(3'd7, 32'h0, 32'h11111111, {1'b1, 32'h11111111});
        sendBeat(3'd7, 32'h0, 32'h22222222, {1'b1, 32'h22222222});
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || err_count !== '0 || out_inst !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset got v=%b c=%0d i=%h expected v=0 c=0 i=0",
                     out_valid, err_count, out_inst);
        end
        expQ.delete();
        expErrCnt = 0;
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
        end
        out_ready = 1'b1;
        sendBeat(3'(B_TYPE), 32'h00000801, 32'h00000063, refEncode(3'(B_TYPE), 32'h00000801, 32'h00000063));
        drain();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_back_to_back();
        test_random();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined RISC-V immediate encoder that scatters a 32-bit immediate into its instruction bit positions according to the stage-1 immediate-type encoding. It is the exact inverse of the stage-1 immediate decode. It serves the test-program generator and the instruction-memory preload path. It accepts a base instruction (opcode/rd/rs1/rs2/funct already placed) plus an immediate, and emits the finished 32-bit instruction over a valid/ready stream, with an optional out-of-range error flag.

## Interface
- `ERR_CNT_W`, default 8: width of the saturating error counter.
- `clk` input, 1 bit: clock; all state updates on its rising edge.
- `reset_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: an input beat is offered.
- `in_ready` output, 1 bit: the block accepts the beat this cycle.
- `in_imm_type` input, 3 bits: immediate type, using the stage-1 codes `R_TYPE`, `I_TYPE`, `ISTAR_TYPE`, `S_TYPE`, `B_TYPE`, `U_TYPE`, `J_TYPE`.
- `in_imm` input, 32 bits: immediate value; sign-extended for I/S/B/J, shift amount for I*.
- `in_base` input, 32 bits: base instruction; the immediate bit positions in it are overwritten.
- `out_valid` output, 1 bit: an output beat is present.
- `out_ready` input, 1 bit: the consumer accepts the output beat.
- `out_inst` output, 32 bits: the encoded instruction.
- `out_err` output, 1 bit: the immediate was not representable for its type.
- `err_count` output, `ERR_CNT_W` bits: saturating count of transferred beats with `out_err`=1.

## Operation
- Transfers: an input transfer occurs when `in_valid`&`in_ready`; an output transfer occurs when `out_valid`&`out_ready`.
- Stage S1 registers the raw `in_imm_type`, `in_imm` and `in_base`.
- Stage S2 registers the packed `out_inst` and `out_err`. It is computed combinationally from S1.
- Packing rule: start from base, then overwrite the immediate fields for the type.
  - R: no change.
  - I: [31:20]=imm[11:0].
  - I*: [24:20]=imm[4:0]; [31:25] is kept from base.
  - S: [31:25]=imm[11:5]; [11:7]=imm[4:0].
  - B: [31]=imm[12]; [7]=imm[11]; [30:25]=imm[10:5]; [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20]; [19:12]=imm[19:12]; [20]=imm[11]; [30:21]=imm[10:1].
  - Undefined code: inst=base, and err=1 regardless of configuration.
- Range rules, giving err=1 when violated:
  - I and S: imm[31:11] all equal.
  - I*: imm[31:5]==0.
  - B: imm[31:12] all equal, and imm[0]==0.
  - U: imm[11:0]==0.
  - J: imm[31:20] all equal, and imm[0]==0.
  - R: never an error.
- When a range rule is violated, bits outside the field are silently dropped.
- Round-trip property: if err=0, decoding `out_inst` with the same type returns `in_imm`.
- `err_count` increments on each output transfer with `out_err`=1 and saturates at all-ones.

## Timing
- Reset values: `out_valid`=0, `out_inst`=0, `out_err`=0, `err_count`=0, S1 valid=0. `in_ready`=1 once reset is released.
- Reset asserted mid-operation clears both stages immediately (asynchronous). Beats in flight are discarded.
- Stage handshake:
  - s2_free = !out_valid | out_ready
  - s1_adv = s1_valid & s2_free
  - in_ready = !s1_valid | s2_free
- `in_ready` is combinational from `out_ready` and state, never from `in_valid`.
- Latency: a beat accepted at edge N is presented from edge N+2 when there is no backpressure.
- Throughput: 1 beat/cycle sustained.
- Simultaneous accept and advance in the same cycle is legal. S1 reloads while S2 takes the old S1 contents.
- Under `out_ready`=0, at most 2 beats are held. `in_ready` drops when both stages are full. Order is preserved and no beat is lost or duplicated.
- `out_inst` and `out_err` are stable while `out_valid`&!`out_ready`.

## Configuration
- `IMMENC_RANGE_CHECK_EN` defined: the range rules and `err_count` are implemented as above.
- `IMMENC_RANGE_CHECK_EN` undefined:
  - Range rules are not checked.
  - `out_err` is 1 only for undefined type codes.
  - `err_count` counts only those beats.
  - Packing and timing are unchanged.

## Structure
- Immediate-type codes come from the shared stage-1 control constants; no local redefinition.
- Sub-module `imm_pack`: purely combinational. Takes (type, imm, base) and returns (inst, err). It is instantiated between S1 and S2 and holds all packing and range logic.
- The top level holds the two pipeline registers, the handshake logic and the counter.

## Test plan
- I, imm=0xFFFFF800, base=0x00000013 -> inst=0x80000013, err=0.
- B, imm=0xFFFFFFFC, base=0x00000063 -> inst=0xFE000EE3, err=0.
- J, imm=0x00000800, base=0x0000006F -> inst=0x0010006F, err=0.
- U, imm=0x12345001, base=0x00000037 -> inst=0x12345037.
  - With `IMMENC_RANGE_CHECK_EN`: err=1 and err_count=1.
  - Without it: err=0 and err_count=0.
- Backpressure: hold `out_ready`=0 and drive 3 back-to-back beats.
  - Required: `in_ready`=0 on the 3rd beat, after 2 beats are held.
  - Then release `out_ready`=1: all 3 beats are delivered in order, one per cycle.
- Reset: pull `reset_n` low while both stages are full -> `out_valid`=0 and `err_count`=0 immediately, without waiting for a clock edge.
